ysyx_24090010_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24090010_mem_arbiter
// PURPOSE
//  Shares the single data/instruction RAM between the IFU (fetch) and the LSU (load/store).
//  Two master ports use valid/ready requests and a one-cycle response pulse.
//  One slave port drives the RAM. Only one transaction is outstanding at a time.
//  Sits in the exu top between ifu/alu-derived LSU signals and the ram instance.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
//  STRB_W  4   byte-strobe width (DATA_W/8)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  ifu_req_valid   in   1       IFU fetch request
//  ifu_req_ready   out  1       IFU request accepted this cycle
//  ifu_addr        in   ADDR_W  fetch address
//  ifu_resp_valid  out  1       one-cycle pulse: ifu_rdata valid
//  ifu_rdata       out  DATA_W  fetched instruction
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_addr        in   ADDR_W  load/store address
//  lsu_wen         in   1       1 = store, 0 = load
//  lsu_wdata       in   DATA_W  store data
//  lsu_strb        in   STRB_W  store byte enables
//  lsu_resp_valid  out  1       one-cycle pulse: load data / store ack
//  lsu_rdata       out  DATA_W  load data (undefined on store ack)
//  mem_req_valid   out  1       request to RAM
//  mem_req_ready   in   1       RAM accepts request
//  mem_addr / mem_wen / mem_wdata / mem_strb  out  ADDR_W/1/DATA_W/STRB_W  registered request fields
//  mem_resp_valid  in   1       RAM response; earliest one cycle after the req handshake
//  mem_rdata       in   DATA_W  RAM read data
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP, DONE. Reset -> IDLE.
//  - IDLE: 2-way round-robin among valid requesters. On a tie, grant the master not served last.
//    - x_req_ready=1 combinationally only for the winner, and only in IDLE.
//    - On that handshake, latch addr/wen/wdata/strb and owner (IFU forces wen=0, strb=0). Go to REQ.
//  - REQ: mem_req_valid=1 with latched fields held stable. On mem_req_ready -> RESP.
//  - RESP: wait for mem_resp_valid. Register mem_rdata into owner's rdata. Go to DONE.
//  - DONE: owner resp_valid=1 for exactly this cycle. Update last-served pointer. -> IDLE.
//    - A new request is accepted at the earliest the next cycle.
//  - Minimum round trip: accept at T, mem handshake at T+1, mem_resp at T+2, resp pulse at T+3.
//  - Unbounded wait in REQ/RESP. No timeout.
//  - mem_resp_valid outside RESP is ignored.
//  - Requests arriving while not in IDLE see ready=0 and must hold. The arbiter never drops a held request.
//  - A master deasserting valid before its handshake is legal; no grant is recorded.
//  - Reset values (asynchronous, also mid-transaction):
//    - state=IDLE, all *_ready/*_valid outputs 0, mem_* fields 0, rdata regs 0.
//    - last-served=IFU, so the first tie goes to the LSU.
//    - A transaction aborted by reset produces no response pulse.
//  - The non-owner's resp_valid is never asserted. At most one resp_valid is high per cycle.
// STRUCTURE
//  - Shared header ysyx_24090010_mem_defs.vh: FSM state encodings (2 bits) and owner encodings OWN_IFU=0 / OWN_LSU=1.
//  - Sub-module ysyx_24090010_rr_arb2: combinational 2-way round-robin. Inputs req[1:0], last; output gnt[1:0] (one-hot or zero).
//  - Top holds the FSM, request/response registers and routing.
// TESTING
//  1. Reset mid-REQ (LSU store in flight): assert rst -> all outputs 0 same cycle; no lsu_resp_valid after release.
//  2. IFU only, addr=0x80000000, RAM returns 0x00000413 one cycle after handshake
//     -> ifu_req_ready at T, mem_req_valid at T+1, ifu_resp_valid+rdata=0x00000413 at T+3.
//  3. LSU store addr=0x80001000, wdata=0xDEADBEEF, strb=4'b0011
//     -> mem_wen=1, fields stable while mem_req_ready held 0 for 3 cycles; one lsu_resp_valid pulse.
//  4. Both valid every cycle after reset -> grants alternate LSU, IFU, LSU, IFU; each master gets a response every other transaction.
//  5. Spurious mem_resp_valid in IDLE and REQ -> no resp pulse; state unchanged.
//  6. RAM response delayed 5 cycles, IFU requests meanwhile -> ifu_req_ready=0 until LSU's DONE; IFU is granted in the following IDLE.

Source files
------------

// File: rtl/ysyx_24090010_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state and owner encodings.
package ysyx_24090010_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;

endpackage

// File: rtl/ysyx_24090010_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin: req[0]=IFU, req[1]=LSU; a tie goes to the
// master that was not served last.
module ysyx_24090010_rr_arb2
    import ysyx_24090010_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == OWN_IFU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_24090010_mem_arbiter.sv
// Shares one RAM between IFU and LSU; one outstanding transaction, fixed
// IDLE -> REQ -> RESP -> DONE sequence with a single-cycle response pulse.
module ysyx_24090010_mem_arbiter
    import ysyx_24090010_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRB_W = DEF_STRB_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_strb,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_strb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t     state_q, state_d;
    owner_t     owner_q, last_q;
    logic [1:0] gnt;
    logic       accept;

    ysyx_24090010_rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    // Ready is masked while reset is held so no handshake is seen during reset.
    assign accept = (state_q == ST_IDLE) && (gnt != 2'b00) && !rst;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ifu_req_ready = accept && gnt[0];
                lsu_req_ready = accept && gnt[1];
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (mem_resp_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                ifu_resp_valid = (owner_q == OWN_IFU);
                lsu_resp_valid = (owner_q == OWN_LSU);
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request/response registers; IFU requests are always plain reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_IFU;
            last_q    <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_strb  <= '0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            if (accept) begin
                if (gnt[1]) begin
                    owner_q   <= OWN_LSU;
                    mem_addr  <= lsu_addr;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_strb  <= lsu_strb;
                end else begin
                    owner_q   <= OWN_IFU;
                    mem_addr  <= ifu_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_strb  <= '0;
                end
            end
            if (state_q == ST_RESP && mem_resp_valid) begin
                if (owner_q == OWN_IFU) ifu_rdata <= mem_rdata;
                else                    lsu_rdata <= mem_rdata;
            end
            if (state_q == ST_DONE) last_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_ysyx_24090010_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_ysyx_24090010_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [SW-1:0] lsu_strb;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_strb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24090010_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_strb       (lsu_strb),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_strb       (mem_strb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_strb       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_strb} !== '0) begin
            errors++;
            $display("FAIL reset_mem_fields got %h/%b/%h/%b want 0", mem_addr, mem_wen, mem_wdata, mem_strb);
        end
        checks++;
        if ({ifu_rdata, lsu_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0", ifu_rdata, lsu_rdata);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ifu_fetch();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_ready_T got %b want 10", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_strb} !== {1'b1, 32'h8000_0000, 1'b0, 4'b0}) begin
            errors++;
            $display("FAIL ifu_mem_req_T1 got v=%b a=%h w=%b s=%b want v=1 a=80000000 w=0 s=0",
                     mem_req_valid, mem_addr, mem_wen, mem_strb);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL ifu_T2 got req=%b resp=%b want 0 0", mem_req_valid, ifu_resp_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0413}) begin
            errors++;
            $display("FAIL ifu_resp_T3 got %b%b %h want 10 00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (ifu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_resp_one_cycle got %b want 0", ifu_resp_valid);
        end
    endtask

    task automatic test_lsu_store_stall();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_strb      = 4'b0011;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lsu_ready got %b want 01", {ifu_req_ready, lsu_req_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_req_ready = (i == 3);
            #1;
            checks++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_strb} !==
                {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
                errors++;
                $display("FAIL lsu_store_hold[%0d] got v=%b a=%h w=%b d=%h s=%b want v=1 a=80001000 w=1 d=deadbeef s=0011",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_strb);
            end
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        #1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin
            errors++;
            $display("FAIL lsu_store_ack got %b want 01", {ifu_resp_valid, lsu_resp_valid});
        end
        @(negedge clk); #1;
        checks++;
        if (lsu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsu_ack_one_cycle got %b want 0", lsu_resp_valid);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h0BAD_F00D;
        lsu_strb      = 4'b1111;
        #1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_setup got %b want 1", mem_req_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
             mem_addr, mem_wen, mem_wdata, mem_strb} !== '0) begin
            errors++;
            $display("FAIL mid_req_reset got v=%b a=%h w=%b d=%h s=%b want all 0",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_strb);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            #1;
            checks++;
            if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d] got %b want 000",
                         i, {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    task automatic test_round_robin();
        logic          lsu_turn;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        for (int k = 0; k < 4; k++) begin
            lsu_turn = (k % 2 == 0);
            exp_addr = lsu_turn ? 32'h0000_0200 : 32'h0000_0100;
            exp_data = 32'h0000_1000 + k;
            @(negedge clk);
            ifu_req_valid  = 1'b1;
            ifu_addr       = 32'h0000_0100;
            lsu_req_valid  = 1'b1;
            lsu_addr       = 32'h0000_0200;
            lsu_wen        = 1'b0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            #1;
            checks++;
            if ({lsu_req_ready, ifu_req_ready} !== (lsu_turn ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant[%0d] got lsu/ifu=%b want %b",
                         k, {lsu_req_ready, ifu_req_ready}, (lsu_turn ? 2'b10 : 2'b01));
            end
            @(negedge clk); #1;
            checks++;
            if (mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL rr_addr[%0d] got %h want %h", k, mem_addr, exp_addr);
            end
            @(negedge clk);
            mem_rdata = exp_data;
            #1;
            @(negedge clk); #1;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid} !== (lsu_turn ? 2'b01 : 2'b10) ||
                (lsu_turn ? lsu_rdata : ifu_rdata) !== exp_data) begin
                errors++;
                $display("FAIL rr_resp[%0d] got ifu/lsu=%b data=%h want %b %h", k,
                         {ifu_resp_valid, lsu_resp_valid}, (lsu_turn ? lsu_rdata : ifu_rdata),
                         (lsu_turn ? 2'b01 : 2'b10), exp_data);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        #1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_idle got %b want 000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0040;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_idle_ready got %b want 1", ifu_req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hEEEE_EEEE;
            #1;
            checks++;
            if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
                errors++;
                $display("FAIL spurious_req[%0d] got %b want 100",
                         i, {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
            end
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        #1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL spurious_final got %b%b %h want 10 cafe0001", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
        end
    endtask

    task automatic test_delayed_resp();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0300;
        lsu_wen       = 1'b0;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL delay_lsu_ready got %b want 1", lsu_req_ready);
        end
        @(negedge clk);
        clear_inputs();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0400;
        mem_req_ready = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ifu_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL delay_ifu_blocked[%0d] got %b want 0", i, ifu_req_ready);
            end
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = (i == 5);
            mem_rdata      = (i == 5) ? 32'h5555_AAAA : 32'h0;
            #1;
        end
        checks++;
        if ({ifu_req_ready, lsu_resp_valid, lsu_rdata} !== {2'b01, 32'h5555_AAAA}) begin
            errors++;
            $display("FAIL delay_lsu_done got ready=%b resp=%b data=%h want 0 1 5555aaaa",
                     ifu_req_ready, lsu_resp_valid, lsu_rdata);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL delay_ifu_granted got %b want 1", ifu_req_ready);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL delay_ifu_addr got %h want 00000400", mem_addr);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0077;
        #1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0077}) begin
            errors++;
            $display("FAIL delay_ifu_resp got %b%b %h want 10 00000077", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_lsu_store_stall();
        test_reset_mid_req();
        test_round_robin();
        test_spurious();
        test_delayed_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
